fp_mul_pipe: RTL and testbench

- IEEE-754 single-precision floating-point multiplier for the FPU datapath.
- Takes two 32-bit operands and produces a 32-bit product plus overflow and underflow flags.
- Two-stage pipeline with a valid handshake; accepts one operation per clock.
- Sits beside the adder/subtractor in the floating-point ALU.

---
 rtl/fp_mul_pipe.sv | 118 +++++++++++
 tb/tb_fp_mul_pipe.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/fp_mul_pipe.sv
// IEEE-754 single-precision multiplier, two register stages, one op per clock.
// Denormal inputs read as signed zero; tiny results flush to signed zero.
module fp_mul_pipe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // ---------------- stage 1: classify, exponent sum, mantissa product
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    assign ea = a[30:23];
    assign eb = b[30:23];
    assign fa = a[22:0];
    assign fb = b[22:0];

    assign a_zero = (ea == 8'h00);
    assign b_zero = (eb == 8'h00);
    assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
    assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
    assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
    assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);

    logic [2:1]  vld_pipe;
    logic        s1_sign, s1_nan, s1_inf, s1_zero;
    logic [9:0]  s1_exp;
    logic [47:0] s1_prod;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            s1_sign  <= 1'b0;
            s1_nan   <= 1'b0;
            s1_inf   <= 1'b0;
            s1_zero  <= 1'b0;
            s1_exp   <= '0;
            s1_prod  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[1], in_valid};
            if (in_valid) begin
                s1_sign <= a[31] ^ b[31];
                // inf*0 folds into the NaN class: both produce the quiet NaN
                s1_nan  <= a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
                s1_inf  <= a_inf | b_inf;
                s1_zero <= a_zero | b_zero;
                s1_exp  <= {2'b00, ea} + {2'b00, eb} - 10'd127;
                s1_prod <= {1'b1, fa} * {1'b1, fb};
            end
        end
    end

    // ---------------- stage 2: normalize, round to nearest even, pack
    logic [22:0]       mant;
    logic              guard, sticky, rup;
    logic [23:0]       mant_r;
    logic signed [9:0] e_n, e_r;
    logic [31:0]       res_d;
    logic              ovf_d, unf_d;

    always_comb begin
        if (s1_prod[47]) begin
            mant   = s1_prod[46:24];
            guard  = s1_prod[23];
            sticky = |s1_prod[22:0];
        end else begin
            mant   = s1_prod[45:23];
            guard  = s1_prod[22];
            sticky = |s1_prod[21:0];
        end
        e_n    = $signed(s1_exp) + $signed({9'd0, s1_prod[47]});
        rup    = guard & (sticky | mant[0]);
        // carry out of the fraction leaves mant_r[22:0] all zero: 1.0 * 2^(e+1)
        mant_r = {1'b0, mant} + {23'd0, rup};
        e_r    = e_n + $signed({9'd0, mant_r[23]});

        res_d = {s1_sign, e_r[7:0], mant_r[22:0]};
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (s1_nan) begin
            res_d = QNAN;
        end else if (s1_inf) begin
            res_d = {s1_sign, 8'hFF, 23'd0};
        end else if (s1_zero) begin
            res_d = {s1_sign, 31'd0};
        end else if (e_r >= 10'sd255) begin
            res_d = {s1_sign, 8'hFF, 23'd0};
            ovf_d = 1'b1;
        end else if (e_r <= 10'sd0) begin
            res_d = {s1_sign, 31'd0};
            unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (vld_pipe[1]) begin
            result    <= res_d;
            overflow  <= ovf_d;
            underflow <= unf_d;
        end
    end

    assign out_valid = vld_pipe[2];

endmodule

// File: tb/tb_fp_mul_pipe.sv
module tb_fp_mul_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        out_valid;
  logic [31:0] result;
  logic        overflow, underflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fp_mul_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
    .out_valid(out_valid), .result(result),
    .overflow(overflow), .underflow(underflow)
  );

  function automatic logic [34:0] obs();
    return {out_valid, result, overflow, underflow};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (obs() !== 35'h0) begin
      n_fail++;
      $display("FAIL reset_state got=%h exp=%h", obs(), 35'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    logic [31:0] va [12], vb [12], vr [12];
    logic [1:0]  vf [12];
    va[0]  = 32'h3F800000; vb[0]  = 32'h3F800000; vr[0]  = 32'h3F800000; vf[0]  = 2'b00;
    va[1]  = 32'h3F800001; vb[1]  = 32'h3F800001; vr[1]  = 32'h3F800002; vf[1]  = 2'b00;
    va[2]  = 32'h7F000000; vb[2]  = 32'h7F000000; vr[2]  = 32'h7F800000; vf[2]  = 2'b10;
    va[3]  = 32'h00800000; vb[3]  = 32'h00800000; vr[3]  = 32'h00000000; vf[3]  = 2'b01;
    va[4]  = 32'h80000000; vb[4]  = 32'h40000000; vr[4]  = 32'h80000000; vf[4]  = 2'b00;
    va[5]  = 32'h7F800000; vb[5]  = 32'h00000000; vr[5]  = 32'h7FC00000; vf[5]  = 2'b00;
    va[6]  = 32'hFF800000; vb[6]  = 32'h40000000; vr[6]  = 32'hFF800000; vf[6]  = 2'b00;
    va[7]  = 32'h7FC00001; vb[7]  = 32'h3F800000; vr[7]  = 32'h7FC00000; vf[7]  = 2'b00;
    va[8]  = 32'h00000001; vb[8]  = 32'hC0000000; vr[8]  = 32'h80000000; vf[8]  = 2'b00;
    va[9]  = 32'h3F800001; vb[9]  = 32'h3FC00000; vr[9]  = 32'h3FC00002; vf[9]  = 2'b00;
    va[10] = 32'h3F800003; vb[10] = 32'h3FC00000; vr[10] = 32'h3FC00004; vf[10] = 2'b00;
    va[11] = 32'hFF7FFFFF; vb[11] = 32'h40000000; vr[11] = 32'hFF800000; vf[11] = 2'b10;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = va[i]; b = vb[i];
      @(negedge clk);
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL early_valid[%0d] got=%b exp=0", i, out_valid);
      end
      @(negedge clk);
      n_checks++;
      if (obs() !== {1'b1, vr[i], vf[i]}) begin
        n_fail++;
        $display("FAIL vector[%0d] got=%h exp=%h", i, obs(), {1'b1, vr[i], vf[i]});
      end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    in_valid = 1'b1; a = 32'h3F800000; b = 32'h3FC00000;
    @(negedge clk);
    a = 32'hBFA00000; b = 32'h3FC00000;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (obs() !== {1'b1, 32'h3FC00000, 2'b00}) begin
      n_fail++;
      $display("FAIL b2b_first got=%h exp=%h", obs(), {1'b1, 32'h3FC00000, 2'b00});
    end
    @(negedge clk);
    n_checks++;
    if (obs() !== {1'b1, 32'hBFF00000, 2'b00}) begin
      n_fail++;
      $display("FAIL b2b_second got=%h exp=%h", obs(), {1'b1, 32'hBFF00000, 2'b00});
    end
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if (obs() !== {1'b0, 32'hBFF00000, 2'b00}) begin
        n_fail++;
        $display("FAIL bubble_hold got=%h exp=%h", obs(), {1'b0, 32'hBFF00000, 2'b00});
      end
    end
  endtask

  task automatic test_reset_inflight();
    @(negedge clk);
    in_valid = 1'b1; a = 32'h40000000; b = 32'h40000000;
    @(negedge clk);
    a = 32'h40400000; b = 32'h40400000;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (obs() !== {1'b1, 32'h40800000, 2'b00}) begin
      n_fail++;
      $display("FAIL pre_reset got=%h exp=%h", obs(), {1'b1, 32'h40800000, 2'b00});
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs() !== 35'h0) begin
      n_fail++;
      $display("FAIL async_reset got=%h exp=%h", obs(), 35'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (obs() !== 35'h0) begin
        n_fail++;
        $display("FAIL stale_after_reset got=%h exp=%h", obs(), 35'h0);
      end
    end
    in_valid = 1'b1; a = 32'h40400000; b = 32'hC0000000;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs() !== {1'b1, 32'hC0C00000, 2'b00}) begin
      n_fail++;
      $display("FAIL post_reset_op got=%h exp=%h", obs(), {1'b1, 32'hC0C00000, 2'b00});
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
